pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 160, meaning width of the datapath payload (PC, instruction, two operands, extended immediate).
REQ-002 Parameter CTRL_W, default 22, meaning width of the control bundle (jump, rd, branch, mem2r, memw, regw, alusrc, extop, aluctrl, shift).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream stage presents a valid instruction.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 flush  input  1  discard all held and incoming instructions (branch/jump redirect).
REQ-010 out_valid  output  1  downstream copy is valid.
REQ-011 out_ready  input  1  downstream stage consumes this cycle.
REQ-012 out_data  output  DATA_W  held payload.
REQ-013 out_ctrl  output  CTRL_W  held control bundle; zero whenever out_valid=0.
REQ-014 count  output  2  number of held entries (0..2).

Function
REQ-015 The stage SHALL hold two slots, main (drives outputs) and skid, each with a valid bit.
REQ-016 in_ready SHALL equal NOT skid_valid, registered (no combinational path from out_ready).
REQ-017 Accept = in_valid AND in_ready; pop = out_valid AND out_ready.
REQ-018 On accept with main empty, or main popping while skid empty, the entry SHALL load main (latency 1 cycle to out_valid).
REQ-019 On accept while main is held (not popping), the entry SHALL load skid.
REQ-020 On pop with skid valid, skid SHALL move to main in the same edge; a simultaneous accept is impossible (in_ready=0).
REQ-021 count SHALL equal main_valid + skid_valid; count=2 forces in_ready=0 next cycle; count never exceeds 2.
REQ-022 With out_ready held 1, the stage SHALL sustain one instruction per cycle with no bubbles.
REQ-023 flush SHALL clear both valid bits and zero out_ctrl on the next edge, overriding any same-cycle accept or pop.
REQ-024 out_data MAY retain stale payload when invalid; out_ctrl SHALL be 0 (NOP semantics) whenever out_valid=0.
REQ-025 Payload and control SHALL pass unmodified; no width conversion.

Reset
REQ-026 While rst=1, all valid bits, out_data, out_ctrl and count SHALL be 0 immediately, independent of clk.
REQ-027 in_ready SHALL be 1 during and after reset; the first accept occurs on the first edge with rst=0.
REQ-028 Reset asserted mid-transfer SHALL discard both slots with no partial output.

Structure
REQ-029 DATA_W/CTRL_W defaults and the control-bundle field offsets SHALL live in shared package pipe_pkg.
REQ-030 One sub-module pipe_slot (valid bit + DATA_W+CTRL_W register with load/clear) SHALL be instantiated twice.
REQ-031 Target 120-400 lines RTL; no memories, no latches.

Verification
REQ-032 Reset: rst=1 mid-stream -> out_valid=0, out_ctrl=0, count=0, in_ready=1 asynchronously.
REQ-033 Streaming: in_valid=1 for 8 cycles, in_data=1..8, out_ready=1 -> outputs 1..8 on consecutive cycles, one-cycle latency.
REQ-034 Backpressure: out_ready=0 after entry 1, send 2,3 -> count=2, in_ready=0; release out_ready -> outputs 1,2,3 in order, none lost or duplicated.
REQ-035 Flush: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_ctrl=0, incoming entry dropped.
REQ-036 Simultaneous pop+accept: count=1, out_ready=1, in_valid=1 data=0xA5 -> next cycle out_data=0xA5, count=1.
REQ-037 Random valid/ready with a scoreboard over 10000 cycles -> in-order, lossless delivery; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and control-bundle layout for the decode/execute skid stage.
// The stage itself treats the control bundle as opaque bits.
package pipe_pkg;

   localparam int DEF_DATA_W = 160;
   localparam int DEF_CTRL_W = 22;

   // Control-bundle field offsets (LSB positions); shift and aluctrl are 5 bits, rd is 5 bits.
   localparam int CTRL_SHIFT_LSB   = 0;
   localparam int CTRL_ALUCTRL_LSB = 5;
   localparam int CTRL_EXTOP_BIT   = 10;
   localparam int CTRL_ALUSRC_BIT  = 11;
   localparam int CTRL_REGW_BIT    = 12;
   localparam int CTRL_MEMW_BIT    = 13;
   localparam int CTRL_MEM2R_BIT   = 14;
   localparam int CTRL_BRANCH_BIT  = 15;
   localparam int CTRL_RD_LSB      = 16;
   localparam int CTRL_JUMP_BIT    = 21;

   typedef struct packed {
      logic       jump;
      logic [4:0] rd;
      logic       branch;
      logic       mem2r;
      logic       memw;
      logic       regw;
      logic       alusrc;
      logic       extop;
      logic [4:0] aluctrl;
      logic [4:0] shift;
   } ctrl_t;

   // Source selected when the main slot loads.
   typedef enum logic {
      SRC_IN   = 1'b0,
      SRC_SKID = 1'b1
   } main_src_e;

endpackage

// File: rtl/pipe_slot.sv
// One holding register: valid bit plus payload/control, with load and clear.
// Clear wins over load and zeroes control so an empty slot always reads as a NOP.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (clr) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
         ctrl_d  = in_ctrl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid    = valid_q;
   assign out_data = data_q;
   assign out_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage: main slot drives the outputs, skid slot absorbs
// one extra entry so in_ready can be a flop instead of a path from out_ready.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        count
);

   logic              main_v, skid_v;
   logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
   logic              main_ld, main_clr, skid_ld, skid_clr;
   logic              accept, pop;
   main_src_e         main_src;

   assign accept = in_valid & ~skid_v;
   assign pop    = main_v & out_ready;

   // Skid is only ever occupied while main is, so main-empty implies skid-empty.
   always_comb begin
      main_ld  = 1'b0;
      main_clr = 1'b0;
      skid_ld  = 1'b0;
      skid_clr = 1'b0;
      main_src = SRC_IN;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (pop) begin
         if (skid_v) begin
            main_ld  = 1'b1;
            main_src = SRC_SKID;
            skid_clr = 1'b1;
         end else if (accept) begin
            main_ld = 1'b1;
         end else begin
            main_clr = 1'b1;
         end
      end else if (accept) begin
         if (main_v) skid_ld = 1'b1;
         else        main_ld = 1'b1;
      end
   end

   assign main_ld_data = (main_src == SRC_SKID) ? skid_data : in_data;
   assign main_ld_ctrl = (main_src == SRC_SKID) ? skid_ctrl : in_ctrl;

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .clk      (clk),
      .rst      (rst),
      .load     (main_ld),
      .clr      (main_clr),
      .in_data  (main_ld_data),
      .in_ctrl  (main_ld_ctrl),
      .valid    (main_v),
      .out_data (main_data),
      .out_ctrl (main_ctrl)
   );

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_ld),
      .clr      (skid_clr),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .valid    (skid_v),
      .out_data (skid_data),
      .out_ctrl (skid_ctrl)
   );

   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_data  = main_data;
   assign out_ctrl  = main_v ? main_ctrl : '0;
   assign count     = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed + random bench for pipe_skid_stage against a queue model of held entries.
module tb_pipe_skid_stage;

   localparam int DW = 160;
   localparam int CW = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   ent_t mq[$];

   pipe_skid_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs expected from the model: the oldest held entry is presented, control is NOP when empty.
   task automatic check_all();
      int sz;
      sz = mq.size();
      chk("out_valid", DW'(out_valid), DW'(sz > 0));
      chk("count", DW'(count), DW'(sz));
      chk("in_ready", DW'(in_ready), DW'(sz < 2));
      chk("out_ctrl", DW'(out_ctrl), (sz > 0) ? DW'(mq[0].c) : '0);
      if (sz > 0) chk("out_data", out_data, mq[0].d);
   endtask

   task automatic cycle();
      ent_t e;
      bit   acc, pp;
      acc = in_valid && (mq.size() < 2);
      pp  = out_ready && (mq.size() > 0);
      e.d = in_data;
      e.c = in_ctrl;
      @(posedge clk);
      if (flush) mq.delete();
      else begin
         if (pp)  void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
      #1;
      check_all();
   endtask

   task automatic rnd_payload();
      for (int i = 0; i < DW / 32; i++) in_data[i*32 +: 32] = $urandom;
      in_ctrl = CW'($urandom);
   endtask

   task automatic send(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = CW'($urandom) | CW'(1);
   endtask

   initial begin
      // Reset holds everything empty before any clock edge.
      #1;
      check_all();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // Streaming, one-cycle latency, no bubbles.
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         send(DW'(k));
         cycle();
         chk("stream_data", out_data, DW'(k));
      end
      in_valid = 1'b0;
      cycle();

      // Backpressure fills both slots, then drains in order.
      out_ready = 1'b0;
      send(DW'(1)); cycle();
      send(DW'(2)); cycle();
      chk("bp_count_full", DW'(count), DW'(2));
      chk("bp_in_ready_low", DW'(in_ready), DW'(0));
      send(DW'(3)); cycle();
      chk("bp_hold_data", out_data, DW'(1));
      out_ready = 1'b1;
      cycle(); chk("bp_drain2", out_data, DW'(2));
      cycle(); chk("bp_drain3", out_data, DW'(3));
      in_valid = 1'b0;
      cycle(); chk("bp_empty", DW'(out_valid), DW'(0));

      // Flush with both slots full and an incoming entry.
      out_ready = 1'b0;
      send(DW'(16'h1111)); cycle();
      send(DW'(16'h2222)); cycle();
      flush = 1'b1;
      send(DW'(16'h3333)); cycle();
      chk("flush_count", DW'(count), DW'(0));
      chk("flush_ctrl", DW'(out_ctrl), DW'(0));
      flush = 1'b0;
      in_valid = 1'b0;
      cycle();

      // Pop and accept on the same edge with one entry held.
      send(DW'(16'h5A5A)); cycle();
      out_ready = 1'b1;
      send(DW'(8'hA5)); cycle();
      chk("simul_data", out_data, DW'(8'hA5));
      chk("simul_count", DW'(count), DW'(1));
      in_valid = 1'b0;
      cycle();

      // Asynchronous reset mid-transfer with two entries held.
      out_ready = 1'b0;
      send(DW'(16'h7777)); cycle();
      send(DW'(16'h8888)); cycle();
      rst = 1'b1;
      #1;
      mq.delete();
      check_all();
      chk("rst_async_count", DW'(count), DW'(0));
      #2;
      rst = 1'b0;
      in_valid = 1'b0;
      cycle();

      // Random valid/ready/flush.
      for (int n = 0; n < 10000; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         rnd_payload();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
